// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: rx pin, baud generator handshake and consumer byte port of the UART receiver
interface uart_rx_ctrl_if #(parameter int DW = 8);
    logic          rx;
    logic          baud_tick;
    logic          baud_ena;
    logic [DW-1:0] data;
    logic          valid;
    logic          rcv;
    logic          data_ack;
    logic          frame_err;
    logic          overrun;
    modport master (input rx, baud_tick, data_ack, output baud_ena, data, valid, rcv, frame_err, overrun);
    modport slave (output rx, baud_tick, data_ack, input baud_ena, data, valid, rcv, frame_err, overrun);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 receive controller sequencing baudgen_rx and holding bytes until acked
module uart_rx_ctrl #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    uart_rx_ctrl_if.master bus
);
    localparam int BW = $clog2(DW + 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, rx_s_d, start_edge;
    logic [BW-1:0]          bitcnt, bitcnt_n;
    logic [DW-1:0]          shreg, shreg_n;
    logic [DW:0]            sh;
    logic                   commit, ferr;
    assign rx_s       = sync[SYNC_STAGES-1];
    assign start_edge = rx_s_d & ~rx_s;
    assign sh         = {rx_s, shreg} >> 1;
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        commit   = 1'b0;
        ferr     = 1'b0;
        case (state)
            IDLE:  state_n = start_edge ? START : IDLE;
            START: if (bus.baud_tick) begin
                state_n  = rx_s ? IDLE : DATA;
                bitcnt_n = '0;
            end
            DATA:  if (bus.baud_tick) begin
                shreg_n  = sh[DW-1:0];
                bitcnt_n = bitcnt + 1'b1;
                state_n  = (bitcnt == BW'(DW - 1)) ? STOP : DATA;
            end
            default: if (bus.baud_tick) begin
                state_n = IDLE;
                commit  = rx_s;
                ferr    = ~rx_s;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            sync          <= '1;
            rx_s_d        <= 1'b1;
            bitcnt        <= '0;
            shreg         <= '0;
            bus.baud_ena  <= 1'b0;
            bus.data      <= '0;
            bus.valid     <= 1'b0;
            bus.rcv       <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            state         <= state_n;
            sync          <= {sync[SYNC_STAGES-2:0], bus.rx};
            rx_s_d        <= rx_s;
            bitcnt        <= bitcnt_n;
            shreg         <= shreg_n;
            bus.baud_ena  <= state_n != IDLE;
            bus.data      <= commit ? shreg : bus.data;
            bus.valid     <= commit | (bus.valid & ~bus.data_ack);
            bus.rcv       <= commit;
            bus.frame_err <= ferr;
            // an ack in the commit cycle consumes the old byte, so no overrun
            bus.overrun   <= (commit & bus.valid & ~bus.data_ack) | (bus.overrun & ~bus.data_ack);
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against a baudgen_rx model, scoreboard-checked
module tb_uart_rx_ctrl;
    localparam int M = 16;
    typedef struct {logic fe; logic [7:0] d; logic ov;} exp_t;
    logic   clk = 1'b0;
    logic   rstn = 1'b0;
    logic   ack = 1'b0;
    logic   ack_on_tick = 1'b0;
    int     cnt = 0;
    int     checks = 0;
    int     errors = 0;
    int     rcv_cnt = 0;
    int     fe_cnt = 0;
    exp_t   q[$];
    uart_rx_ctrl_if #(.DW(8)) bus ();
    uart_rx_ctrl #(.DW(8), .SYNC_STAGES(2)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cnt <= !bus.baud_ena ? 0 : (cnt == M - 1 ? 0 : cnt + 1);
    assign bus.baud_tick = bus.baud_ena && cnt == M / 2;
    assign bus.data_ack  = ack | (ack_on_tick & bus.baud_tick);
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (rstn && (bus.rcv || bus.frame_err)) begin
            if (bus.rcv) rcv_cnt++;
            if (bus.frame_err) fe_cnt++;
            if (q.size() == 0) chk("unexpected_event", {14'd0, bus.rcv, bus.frame_err}, 16'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("event_kind", {14'd0, bus.rcv, bus.frame_err}, {14'd0, ~e.fe, e.fe});
                chk("event_data", {8'd0, bus.data}, {8'd0, e.d});
                chk("event_overrun", {15'd0, bus.overrun}, {15'd0, e.ov});
                if (!e.fe) chk("event_valid", {15'd0, bus.valid}, 16'd1);
            end
        end
    end
    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (M) @(posedge clk);
    endtask
    task automatic send(input logic [7:0] d, input logic stop, input logic ov, input logic [7:0] held);
        exp_t e;
        e.fe = ~stop;
        e.d  = stop ? d : held;
        e.ov = ov;
        q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        bus.rx = 1'b1;
        repeat (8) @(posedge clk);
    endtask
    task automatic do_ack();
        @(posedge clk);
        ack = 1'b1;
        @(posedge clk);
        ack = 1'b0;
    endtask
    task automatic outs(input string name, input logic [7:0] d, input logic v, input logic ov);
        @(negedge clk);
        chk({name, "_data"}, {8'd0, bus.data}, {8'd0, d});
        chk({name, "_valid"}, {15'd0, bus.valid}, {15'd0, v});
        chk({name, "_overrun"}, {15'd0, bus.overrun}, {15'd0, ov});
        chk({name, "_baud_ena"}, {15'd0, bus.baud_ena}, 16'd0);
    endtask
    initial begin
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        outs("reset", 8'h00, 1'b0, 1'b0);
        chk("reset_pulses", {14'd0, bus.rcv, bus.frame_err}, 16'd0);
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        send(8'h55, 1'b1, 1'b0, 8'h00);
        outs("t1", 8'h55, 1'b1, 1'b0);
        chk("t1_rcv_count", 16'(rcv_cnt), 16'd1);
        do_ack();
        outs("t1_ack", 8'h55, 1'b0, 1'b0);
        bus.rx = 1'b0;
        repeat (3) @(posedge clk);
        bus.rx = 1'b1;
        repeat (40) @(posedge clk);
        outs("t2", 8'h55, 1'b0, 1'b0);
        chk("t2_pulses", 16'(rcv_cnt + fe_cnt), 16'd1);
        send(8'hA3, 1'b0, 1'b0, 8'h55);
        outs("t3_err", 8'h55, 1'b0, 1'b0);
        chk("t3_fe_count", 16'(fe_cnt), 16'd1);
        send(8'h3C, 1'b1, 1'b0, 8'h00);
        outs("t3_next", 8'h3C, 1'b1, 1'b0);
        do_ack();
        send(8'h11, 1'b1, 1'b0, 8'h00);
        send(8'h22, 1'b1, 1'b1, 8'h00);
        outs("t4", 8'h22, 1'b1, 1'b1);
        do_ack();
        outs("t4_ack", 8'h22, 1'b0, 1'b0);
        ack_on_tick = 1'b1;
        send(8'h7E, 1'b1, 1'b0, 8'h00);
        ack_on_tick = 1'b0;
        outs("t5", 8'h7E, 1'b1, 1'b0);
        do_ack();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        bus.rx = 1'b1;
        repeat (5) @(posedge clk);
        rstn = 1'b0;
        @(posedge clk);
        rstn = 1'b1;
        outs("t6_reset", 8'h00, 1'b0, 1'b0);
        chk("t6_pulses", {14'd0, bus.rcv, bus.frame_err}, 16'd0);
        repeat (40) @(posedge clk);
        send(8'hF0, 1'b1, 1'b0, 8'h00);
        outs("t6_frame", 8'hF0, 1'b1, 1'b0);
        chk("pending_events", 16'(q.size()), 16'd0);
        chk("total_rcv", 16'(rcv_cnt), 16'd6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
